// File: rtl/ifetch.sv
// Instruction fetch: one outstanding request, single-entry IR, redirect squash.
// Define IFETCH_TIMEOUT_EN to turn a stuck fetch into a NOP plus a bus_err pulse.
module ifetch (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] pc_out,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic        sq_done;

    assign mem_req = !rst && (state == FETCH || state == SQUASH);

`ifdef IFETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       tmo;
    logic       berr_q;

    assign tmo     = (tmo_cnt == 4'hF);
    assign sq_done = mem_ack || tmo;
    assign bus_err = berr_q;
`else
    assign sq_done = mem_ack;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= 16'h0000;
            mem_addr <= 16'h0000;
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
            pc_out   <= 16'h0000;
`ifdef IFETCH_TIMEOUT_EN
            tmo_cnt  <= 4'h0;
            berr_q   <= 1'b0;
`endif
        end else begin
`ifdef IFETCH_TIMEOUT_EN
            berr_q <= 1'b0;
            if (mem_req && !mem_ack)
                tmo_cnt <= tmo_cnt + 4'h1;
            else
                tmo_cnt <= 4'h0;
`endif
            unique case (state)
                FETCH: begin
                    if (redirect_en) begin
                        pc <= redirect_pc;
                        // With ack the old beat is dropped and the
                        // new address goes out next cycle.
                        if (mem_ack) begin
                            mem_addr <= redirect_pc;
                        end else begin
                            state <= SQUASH;
`ifdef IFETCH_TIMEOUT_EN
                            tmo_cnt <= 4'h0;
`endif
                        end
                    end else if (mem_ack) begin
                        ir       <= mem_rdata;
                        pc_out   <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + 16'd1;
                        state    <= HOLD;
`ifdef IFETCH_TIMEOUT_EN
                    end else if (tmo) begin
                        berr_q   <= 1'b1;
                        ir       <= 16'h0000;
                        pc_out   <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + 16'd1;
                        state    <= HOLD;
                        tmo_cnt  <= 4'h0;
`endif
                    end
                end
                SQUASH: begin
                    if (redirect_en)
                        pc <= redirect_pc;
                    if (sq_done) begin
                        state    <= FETCH;
                        mem_addr <= redirect_en ? redirect_pc : pc;
`ifdef IFETCH_TIMEOUT_EN
                        tmo_cnt  <= 4'h0;
`endif
                    end
                end
                HOLD: begin
                    if (redirect_en) begin
                        ir_valid <= 1'b0;
                        pc       <= redirect_pc;
                        mem_addr <= redirect_pc;
                        state    <= FETCH;
                    end else if (ir_ready) begin
                        ir_valid <= 1'b0;
                        mem_addr <= pc;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level fetch model.
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] pc_out;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        bus_err;

    ifetch dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .pc_out      (pc_out),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IFETCH_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Reference: holding (valid instruction), squashing (dead request in
    // flight) or fetching (live request); wait counts unacked cycles.
    logic [15:0] m_pc, m_addr, m_ir, m_pcout;
    bit          m_valid, m_squash, m_berr;
    int          m_wait;

    task automatic cmp(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s at %0t: got %h, expected %h",
                     name, $time, act, exp);
    endtask

    function automatic void deliver(input logic [15:0] d);
        m_ir    = d;
        m_pcout = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 16'd1;
        m_wait  = 0;
    endfunction

    function automatic void model_step();
        m_berr = 1'b0;
        if (rst) begin
            m_pc = 16'h0; m_addr = 16'h0; m_ir = 16'h0; m_pcout = 16'h0;
            m_valid = 1'b0; m_squash = 1'b0; m_wait = 0;
        end else if (m_valid) begin
            if (redirect_en || ir_ready) begin
                if (redirect_en) m_pc = redirect_pc;
                m_valid = 1'b0;
                m_addr  = m_pc;
                m_wait  = 0;
            end
        end else if (m_squash) begin
            if (redirect_en) m_pc = redirect_pc;
            if (mem_ack || (TMO && m_wait == 15)) begin
                m_squash = 1'b0;
                m_addr   = m_pc;
                m_wait   = 0;
            end else begin
                m_wait++;
            end
        end else begin
            if (redirect_en) begin
                m_pc = redirect_pc;
                if (mem_ack) m_addr = m_pc;
                else m_squash = 1'b1;
                m_wait = 0;
            end else if (mem_ack) begin
                deliver(mem_rdata);
            end else if (TMO && m_wait == 15) begin
                deliver(16'h0000);
                m_berr = 1'b1;
            end else begin
                m_wait++;
            end
        end
    endfunction

    task automatic check_all();
        cmp("mem_req",  {15'b0, mem_req},  {15'b0, (!rst && !m_valid)});
        cmp("mem_addr", mem_addr, m_addr);
        cmp("ir",       ir,       m_ir);
        cmp("ir_valid", {15'b0, ir_valid}, {15'b0, m_valid});
        cmp("pc_out",   pc_out,   m_pcout);
        cmp("bus_err",  {15'b0, bus_err},  {15'b0, m_berr});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic step(input bit a, input logic [15:0] d, input bit rdy,
                        input bit re, input logic [15:0] rp);
        mem_ack     = a;
        mem_rdata   = d;
        ir_ready    = rdy;
        redirect_en = re;
        redirect_pc = rp;
        tick();
    endtask

    int n;
    bit slow;

    initial begin
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        ir_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h1234;
        tick();
        tick();
        cmp("rst_ir_valid", {15'b0, ir_valid}, 16'h0);
        cmp("rst_ir",       ir,       16'h0000);
        cmp("rst_addr",     mem_addr, 16'h0000);
        cmp("rst_req",      {15'b0, mem_req}, 16'h0);
        rst = 1'b0;
        #1;
        cmp("first_req",  {15'b0, mem_req}, 16'h1);
        cmp("first_addr", mem_addr, 16'h0000);

        step(0, 16'h0, 1, 0, 16'h0);
        step(1, 16'h1A05, 1, 0, 16'h0);
        cmp("i0_ir", ir, 16'h1A05);
        cmp("i0_pc", pc_out, 16'h0000);
        step(0, 16'h0, 1, 0, 16'h0);
        cmp("addr1", mem_addr, 16'h0001);
        step(0, 16'h0, 1, 0, 16'h0);
        step(1, 16'h2C81, 1, 0, 16'h0);
        cmp("i1_ir", ir, 16'h2C81);
        cmp("i1_pc", pc_out, 16'h0001);
        step(0, 16'h0, 1, 0, 16'h0);
        cmp("addr2", mem_addr, 16'h0002);

        step(1, 16'h3333, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 16'h0, 0, 0, 16'h0);
            cmp("hold_ir",    ir, 16'h3333);
            cmp("hold_valid", {15'b0, ir_valid}, 16'h1);
            cmp("hold_req",   {15'b0, mem_req},  16'h0);
        end
        step(0, 16'h0, 1, 0, 16'h0);
        cmp("addr3", mem_addr, 16'h0003);

        step(0, 16'h0, 0, 0, 16'h0);
        step(0, 16'h0, 0, 1, 16'h0040);
        cmp("sq_addr", mem_addr, 16'h0003);
        cmp("sq_req",  {15'b0, mem_req}, 16'h1);
        step(1, 16'hBEEF, 0, 0, 16'h0);
        cmp("sq_valid", {15'b0, ir_valid}, 16'h0);
        cmp("sq_next",  mem_addr, 16'h0040);

        step(1, 16'h4444, 0, 0, 16'h0);
        cmp("i40_pc", pc_out, 16'h0040);
        step(0, 16'h0, 1, 1, 16'h0100);
        cmp("hr_valid", {15'b0, ir_valid}, 16'h0);
        cmp("hr_addr",  mem_addr, 16'h0100);

        step(1, 16'h5555, 0, 1, 16'hFFFF);
        cmp("fr_addr", mem_addr, 16'hFFFF);
        cmp("fr_ir",   ir, 16'h4444);
        step(1, 16'h6666, 0, 0, 16'h0);
        cmp("wrap_pc", pc_out, 16'hFFFF);
        step(0, 16'h0, 1, 0, 16'h0);
        cmp("wrap_addr", mem_addr, 16'h0000);

        step(1, 16'h0, 0, 1, 16'h0007);
        cmp("to_addr", mem_addr, 16'h0007);
`ifdef IFETCH_TIMEOUT_EN
        n = 0;
        while (n < 40 && !bus_err) begin
            step(0, 16'h0, 0, 0, 16'h0);
            n++;
        end
        cmp("to_cycles", 16'(n), 16'd16);
        cmp("to_ir",     ir, 16'h0000);
        cmp("to_pc",     pc_out, 16'h0007);
        cmp("to_valid",  {15'b0, ir_valid}, 16'h1);
        step(0, 16'h0, 0, 0, 16'h0);
        cmp("to_pulse",  {15'b0, bus_err}, 16'h0);
        step(0, 16'h0, 1, 0, 16'h0);
        cmp("to_next",   mem_addr, 16'h0008);
`else
        for (int i = 0; i < 40; i++) begin
            step(0, 16'h0, 0, 0, 16'h0);
            cmp("nt_valid", {15'b0, ir_valid}, 16'h0);
            cmp("nt_berr",  {15'b0, bus_err},  16'h0);
        end
        step(1, 16'h7777, 0, 0, 16'h0);
        cmp("nt_ir", ir, 16'h7777);
        cmp("nt_pc", pc_out, 16'h0007);
`endif

        for (int c = 0; c < 3000; c++) begin
            slow = ((c / 250) % 4) == 3;
            rst = ($urandom_range(299) == 0);
            if (!m_valid)
                mem_ack = slow ? ($urandom_range(23) == 0) : $urandom_range(1);
            else
                mem_ack = ($urandom_range(7) == 0);
            mem_rdata   = 16'($urandom);
            ir_ready    = $urandom_range(1);
            redirect_en = ($urandom_range(7) == 0);
            redirect_pc = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
